// File: rtl/bnn_seq_ctrl.sv
// bnn_seq_ctrl
//   Control sequencer for the 8-8-4 XNOR-popcount BNN datapath. It owns every
//   datapath control pin and offers two operations:
//     * reprogram: pulse the datapath reset to clear its load pointer, then
//       stream NUM_NEURONS weight bytes into the nibble-serial load port,
//       low nibble first.
//     * inference: register an input vector onto dp_x, wait for the
//       datapath pipeline, then capture and report the classification.
//   The datapath's ena pin is tied high at the top level and is not a port here.
//
// Ports
//   clk, rst_n                : clock, asynchronous active-low reset
//   cfg_start                 : one-cycle request to reprogram all weights
//   wt_data/wt_valid/wt_ready : weight byte stream (valid/ready)
//   cfg_done                  : one-cycle pulse when the last byte is written
//   x_in/x_valid/x_ready      : input vector stream (valid/ready)
//   y_out/y_valid             : classification (held), one-cycle update pulse
//   busy                      : high whenever the sequencer is not idle
//   dp_rst_n, dp_load_en,
//   dp_nibble, dp_x           : datapath control outputs
//   dp_y                      : datapath registered layer-2 output
module bnn_seq_ctrl #(
  parameter int NUM_NEURONS = 12,
  parameter int PIPE_LAT    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_start,
  input  logic [7:0] wt_data,
  input  logic       wt_valid,
  output logic       wt_ready,
  output logic       cfg_done,
  input  logic [7:0] x_in,
  input  logic       x_valid,
  output logic       x_ready,
  output logic [3:0] y_out,
  output logic       y_valid,
  output logic       busy,
  output logic       dp_rst_n,
  output logic       dp_load_en,
  output logic [3:0] dp_nibble,
  output logic [7:0] dp_x,
  input  logic [3:0] dp_y
);

  localparam int CW = $clog2(NUM_NEURONS + 1);
  localparam int PW = $clog2(PIPE_LAT + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_DP_RST  = 3'd1;
  localparam logic [2:0] S_LD_WAIT = 3'd2;
  localparam logic [2:0] S_LD_LO   = 3'd3;
  localparam logic [2:0] S_LD_HI   = 3'd4;
  localparam logic [2:0] S_INFER   = 3'd5;

  logic [2:0]    state_reg,    state_next;
  logic [CW-1:0] byte_cnt_reg, byte_cnt_next;
  logic [PW-1:0] pipe_cnt_reg, pipe_cnt_next;
  logic [7:0]    wt_byte_reg,  wt_byte_next;
  logic [7:0]    dp_x_reg,     dp_x_next;
  logic [3:0]    y_out_reg,    y_out_next;
  logic          y_valid_reg,  y_valid_next;
  logic          cfg_done_reg, cfg_done_next;
  logic          dp_rst_n_reg, dp_rst_n_next;

  always_comb begin
    state_next    = state_reg;
    byte_cnt_next = byte_cnt_reg;
    pipe_cnt_next = pipe_cnt_reg;
    wt_byte_next  = wt_byte_reg;
    dp_x_next     = dp_x_reg;
    y_out_next    = y_out_reg;
    y_valid_next  = 1'b0;
    cfg_done_next = 1'b0;

    case (state_reg)
      S_IDLE: begin
        // A reprogram request takes priority over a pending vector.
        if (cfg_start) begin
          state_next = S_DP_RST;
        end else if (x_valid) begin
          dp_x_next     = x_in;
          pipe_cnt_next = '0;
          state_next    = S_INFER;
        end
      end
      S_DP_RST: begin
        byte_cnt_next = '0;
        state_next    = S_LD_WAIT;
      end
      S_LD_WAIT: begin
        if (wt_valid) begin
          wt_byte_next = wt_data;
          state_next   = S_LD_LO;
        end
      end
      S_LD_LO: begin
        state_next = S_LD_HI;
      end
      S_LD_HI: begin
        byte_cnt_next = byte_cnt_reg + CW'(1);
        if (byte_cnt_next == CW'(NUM_NEURONS)) begin
          cfg_done_next = 1'b1;
          state_next    = S_IDLE;
        end else begin
          state_next = S_LD_WAIT;
        end
      end
      S_INFER: begin
        pipe_cnt_next = pipe_cnt_reg + PW'(1);
        // dp_y reflects dp_x once PIPE_LAT datapath edges have passed.
        if (pipe_cnt_reg == PW'(PIPE_LAT)) begin
          y_out_next   = dp_y;
          y_valid_next = 1'b1;
          state_next   = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    // Registered so the datapath stays in reset with the controller and is
    // released on the first edge after rst_n deasserts.
    dp_rst_n_next = (state_next != S_DP_RST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      byte_cnt_reg <= '0;
      pipe_cnt_reg <= '0;
      wt_byte_reg  <= '0;
      dp_x_reg     <= '0;
      y_out_reg    <= '0;
      y_valid_reg  <= 1'b0;
      cfg_done_reg <= 1'b0;
      dp_rst_n_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      byte_cnt_reg <= byte_cnt_next;
      pipe_cnt_reg <= pipe_cnt_next;
      wt_byte_reg  <= wt_byte_next;
      dp_x_reg     <= dp_x_next;
      y_out_reg    <= y_out_next;
      y_valid_reg  <= y_valid_next;
      cfg_done_reg <= cfg_done_next;
      dp_rst_n_reg <= dp_rst_n_next;
    end
  end

  // Datapath controls decode from registered state only.
  assign dp_load_en = (state_reg == S_LD_LO) || (state_reg == S_LD_HI);
  assign dp_nibble  = (state_reg == S_LD_LO) ? wt_byte_reg[3:0] :
                      (state_reg == S_LD_HI) ? wt_byte_reg[7:4] : 4'h0;
  assign dp_rst_n   = dp_rst_n_reg;
  assign dp_x       = dp_x_reg;

  assign wt_ready = (state_reg == S_LD_WAIT);
  assign x_ready  = (state_reg == S_IDLE);
  assign busy     = (state_reg != S_IDLE);
  assign cfg_done = cfg_done_reg;
  assign y_out    = y_out_reg;
  assign y_valid  = y_valid_reg;

endmodule

// File: tb/tb_bnn_seq_ctrl.sv
// Bench for bnn_seq_ctrl: a cycle-level datapath model sits on the dp_* pins,
// and a behavioural BNN evaluation of the weights the bench intended to load
// provides expected classifications.
module tb_bnn_seq_ctrl;

  localparam int NN = 12;
  typedef logic [NN-1:0][7:0] wset_t;
  localparam wset_t DEF_W = {8'hC3, 8'h5A, 8'h0F, 8'hF0, 8'h96, 8'h69,
                             8'h33, 8'hCC, 8'h55, 8'hAA, 8'h81, 8'h7E};

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cfg_start = 1'b0;
  logic [7:0] wt_data = 8'h00;
  logic       wt_valid = 1'b0;
  logic [7:0] x_in = 8'h00;
  logic       x_valid = 1'b0;
  logic       wt_ready, cfg_done, x_ready, y_valid, busy;
  logic       dp_rst_n, dp_load_en;
  logic [3:0] y_out, dp_nibble, dp_y;
  logic [7:0] dp_x;

  always #5 clk = ~clk;

  bnn_seq_ctrl #(.NUM_NEURONS(NN), .PIPE_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start),
    .wt_data(wt_data), .wt_valid(wt_valid), .wt_ready(wt_ready),
    .cfg_done(cfg_done), .x_in(x_in), .x_valid(x_valid), .x_ready(x_ready),
    .y_out(y_out), .y_valid(y_valid), .busy(busy),
    .dp_rst_n(dp_rst_n), .dp_load_en(dp_load_en), .dp_nibble(dp_nibble),
    .dp_x(dp_x), .dp_y(dp_y)
  );

  // Behavioural BNN: neuron fires when at least half of its XNOR bits match.
  function automatic logic [7:0] layer1(input wset_t w, input logic [7:0] x);
    logic [7:0] h, t;
    h = '0;
    for (int j = 0; j < 8; j++) begin
      t = ~(x ^ w[j]);
      h[j] = ($countones(t) >= 4);
    end
    return h;
  endfunction

  function automatic logic [3:0] layer2(input wset_t w, input logic [7:0] h);
    logic [3:0] y;
    logic [7:0] t;
    y = '0;
    for (int k = 0; k < 4; k++) begin
      t = ~(h ^ w[8+k]);
      y[k] = ($countones(t) >= 4);
    end
    return y;
  endfunction

  function automatic logic [3:0] bnn_ref(input wset_t w, input logic [7:0] x);
    return layer2(w, layer1(w, x));
  endfunction

  // Datapath model: nibble-serial weight load, two register stages.
  wset_t      dp_w;
  logic [4:0] ld_ptr;
  logic [7:0] h_r;
  logic [3:0] y_r;
  assign dp_y = y_r;

  always @(posedge clk or negedge dp_rst_n) begin
    if (!dp_rst_n) begin
      dp_w   <= DEF_W;
      ld_ptr <= '0;
      h_r    <= '0;
      y_r    <= '0;
    end else begin
      if (dp_load_en) begin
        if (ld_ptr < 5'd24) begin
          if (ld_ptr[0]) dp_w[ld_ptr[4:1]][7:4] <= dp_nibble;
          else           dp_w[ld_ptr[4:1]][3:0] <= dp_nibble;
        end
        ld_ptr <= ld_ptr + 5'd1;
      end
      h_r <= layer1(dp_w, dp_x);
      y_r <= layer2(dp_w, h_r);
    end
  end

  // Monitor, sampled on the falling edge.
  int         cyc = 0;
  logic [3:0] ld_q[$];
  int         rstlow_cnt = 0;
  int         overlap_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dp_load_en) ld_q.push_back(dp_nibble);
    if (rst_n && !dp_rst_n) rstlow_cnt++;
    if (y_valid && cfg_done) overlap_cnt++;
  end

  int         err_cnt = 0;
  int         chk_cnt = 0;
  wset_t      cur_w = DEF_W;
  logic [7:0] last_x = 8'h00;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    check(tag, {dp_rst_n, dp_load_en, dp_nibble, dp_x, y_out, y_valid,
                cfg_done, busy, wt_ready, x_ready},
          {1'b0, 1'b0, 4'h0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
  endtask

  // mode 0: wt_valid always high, 1: every other cycle, 2: random.
  task automatic load_weights(input string tag, input wset_t b, input int mode,
                              input bit conflict, input int abort_after, input int exp_done);
    int idx, done_c, rl0;
    bit acc;
    logic [95:0] got_s, exp_s;
    idx = 0; acc = 1'b0; done_c = -1; rl0 = rstlow_cnt;
    ld_q.delete();
    cfg_start = 1'b1;
    if (conflict) begin
      x_in = 8'h5A;
      x_valid = 1'b1;
      check({tag, "_conf_xrdy"}, x_ready, 1);
    end
    for (int c = 1; c <= 200; c++) begin
      step();
      cfg_start = 1'b0;
      x_valid = 1'b0;
      if (c == 1) check({tag, "_dprst"}, {dp_rst_n, busy, wt_ready}, 3'b010);
      if (acc) idx++;
      acc = 1'b0;
      if (abort_after > 0 && idx >= abort_after) begin
        wt_valid = 1'b0;
        return;
      end
      if (cfg_done) begin
        done_c = c;
        break;
      end
      case (mode)
        0:       wt_valid = 1'b1;
        1:       wt_valid = (c % 2 == 1);
        default: wt_valid = 1'($urandom_range(0, 1));
      endcase
      wt_data = (idx < NN) ? b[idx] : 8'hEE;
      acc = wt_valid && wt_ready;
    end
    wt_valid = 1'b0;
    if (exp_done > 0) check({tag, "_done_cyc"}, done_c, exp_done);
    else              check({tag, "_done_seen"}, (done_c > 0), 1);
    check({tag, "_rst_pulses"}, rstlow_cnt - rl0, 1);
    exp_s = '0;
    got_s = '0;
    for (int i = 0; i < NN; i++) begin
      exp_s[8*i +: 4]   = b[i][3:0];
      exp_s[8*i+4 +: 4] = b[i][7:4];
    end
    for (int i = 0; i < ld_q.size() && i < 2*NN; i++) got_s[4*i +: 4] = ld_q[i];
    check({tag, "_strobes"}, ld_q.size(), 2*NN);
    check({tag, "_nibbles"}, got_s, exp_s);
    check({tag, "_dp_w"}, dp_w, b);
    check({tag, "_dp_x_kept"}, dp_x, last_x);
    step();
    check({tag, "_done_pulse"}, {cfg_done, busy}, 2'b00);
    cur_w = b;
  endtask

  task automatic infer(input string tag, input logic [7:0] x, input bit poke);
    int c, rl0;
    rl0 = rstlow_cnt;
    x_in = x;
    x_valid = 1'b1;
    c = 0;
    while (!x_ready && c < 20) begin step(); c++; end
    check({tag, "_xrdy"}, x_ready, 1);
    step();
    x_valid = 1'b0;
    last_x = x;
    if (poke) cfg_start = 1'b1;
    c = 1;
    while (!y_valid && c < 12) begin step(); cfg_start = 1'b0; c++; end
    cfg_start = 1'b0;
    check({tag, "_lat"}, c, 4);
    check({tag, "_y"}, y_out, bnn_ref(cur_w, x));
    check({tag, "_dp_x"}, dp_x, x);
    check({tag, "_no_dprst"}, rstlow_cnt - rl0, 0);
  endtask

  task automatic back_to_back();
    logic [7:0] vecs [3];
    int acc_c [3];
    int i, nres;
    vecs[0] = 8'hFF; vecs[1] = 8'h00; vecs[2] = 8'h07;
    acc_c[0] = 0; acc_c[1] = 0; acc_c[2] = 0;
    i = 0; nres = 0;
    for (int t = 0; t < 40 && nres < 3; t++) begin
      if (y_valid) begin
        check($sformatf("b2b_y%0d", nres), y_out, bnn_ref(cur_w, vecs[nres]));
        nres++;
      end
      if (i < 3) begin
        x_in = vecs[i];
        x_valid = 1'b1;
        if (x_ready) begin acc_c[i] = cyc; i++; end
      end else begin
        x_valid = 1'b0;
      end
      step();
    end
    x_valid = 1'b0;
    last_x = vecs[2];
    check("b2b_results", nres, 3);
    check("b2b_gap1", acc_c[1] - acc_c[0], 4);
    check("b2b_gap2", acc_c[2] - acc_c[1], 4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    wset_t b;
    #2 rst_n = 1'b0;
    for (int r = 0; r < 3; r++) begin
      step();
      chk_reset($sformatf("reset_c%0d", r));
    end
    rst_n = 1'b1;
    step();
    check("reset_release", {dp_rst_n, x_ready, busy}, 3'b110);

    infer("def_E0", 8'hE0, 1'b0);

    for (int i = 0; i < NN; i++) b[i] = 8'(i * 8'h11);
    load_weights("full", b, 0, 1'b0, 0, 38);
    back_to_back();

    load_weights("throttle", b, 1, 1'b0, 0, 0);
    infer("thr_inf", 8'hA3, 1'b1);

    for (int i = 0; i < NN; i++) b[i] = 8'($urandom);
    load_weights("conflict", b, 2, 1'b1, 0, 0);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NN; i++) b[i] = 8'($urandom);
      load_weights($sformatf("rnd%0d", r), b, 2, 1'($urandom_range(0, 1)), 0, 0);
      for (int v = 0; v < 5; v++) begin
        repeat ($urandom_range(0, 3)) step();
        infer($sformatf("rnd%0d_v%0d", r, v), 8'($urandom), 1'($urandom_range(0, 1)));
      end
    end

    for (int i = 0; i < NN; i++) b[i] = 8'($urandom);
    load_weights("abort", b, 0, 1'b0, 5, 0);
    rst_n = 1'b0;
    step();
    chk_reset("abort_rst");
    step();
    rst_n = 1'b1;
    step();
    cur_w = DEF_W;
    last_x = 8'h00;
    check("abort_release", {dp_rst_n, busy}, 2'b10);
    check("abort_dp_w", dp_w, DEF_W);
    infer("abort_E0", 8'hE0, 1'b0);

    check("overlap", overlap_cnt, 0);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
